ycbcr_capture: RTL and testbench

YCBCR_CAPTURE -- requirements
Module: ycbcr_capture

---
 rtl/ycbcr_pkg.sv | 20 ++
 rtl/sync_edge.sv | 24 ++
 rtl/ycbcr_capture.sv | 145 ++++++++++++++
 tb/tb_ycbcr_capture.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycbcr_pkg.sv
// Shared definitions for the UYVY capture path and the downstream colour-detect stage.
// Holds the byte-phase encoding and the default active-window size.
package ycbcr_pkg;

    typedef enum logic [1:0] {
        PH_CB = 2'd0,
        PH_Y0 = 2'd1,
        PH_CR = 2'd2,
        PH_Y1 = 2'd3
    } phase_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // The UYVY order wraps from Y1 back to Cb.
    function automatic phase_t phase_next(input phase_t p);
        return phase_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Registered edge detector: keeps the previous sample of a level signal and
// flags a rising or falling transition at the current sample.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/ycbcr_capture.sv
// UYVY camera byte-stream capture: reassembles Cb/Y0/Cr/Y1 groups into two pixels,
// tracks column/row within the active window and reports frame end and overflow.
module ycbcr_capture
    import ycbcr_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic       PCLK,
    input  logic       reset,
    input  logic       VSYNC,
    input  logic       HREF,
    input  logic [7:0] D,
    output logic       e_pix,
    output logic [7:0] Y,
    output logic [7:0] Cb,
    output logic [7:0] Cr,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       frame_done,
    output logic       overflow
);

    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

    logic   href_rise, href_fall;
    logic   vs_rise, vs_fall;
    phase_t phase, phase_nx, cur_phase;
    logic   armed, armed_nx;
    logic   accept, pix_done, in_range;
    logic [9:0] col;
    logic [8:0] row;
    logic       line_pix;
    logic [7:0] cb_r, y0_r, cr_r;

    sync_edge u_href_edge (
        .clk   (PCLK),
        .reset (reset),
        .sig   (HREF),
        .rise  (href_rise),
        .fall  (href_fall)
    );

    sync_edge u_vsync_edge (
        .clk   (PCLK),
        .reset (reset),
        .sig   (VSYNC),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    // Capture stays disarmed until a full frame boundary has been seen.
    always_comb begin
        armed_nx  = armed | vs_fall;
        accept    = armed && !VSYNC && HREF;
        cur_phase = href_rise ? PH_CB : phase;
        phase_nx  = phase;
        if (VSYNC) begin
            phase_nx = PH_CB;
        end else if (accept) begin
            phase_nx = phase_next(cur_phase);
        end
        pix_done = accept && (cur_phase == PH_CR || cur_phase == PH_Y1);
        in_range = (col < H_LIM) && (row < V_LIM);
    end

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            phase <= PH_CB;
            armed <= 1'b0;
        end else begin
            phase <= phase_nx;
            armed <= armed_nx;
        end
    end

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            e_pix      <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            Y          <= '0;
            Cb         <= '0;
            Cr         <= '0;
            x          <= '0;
            y          <= '0;
            col        <= '0;
            row        <= '0;
            line_pix   <= 1'b0;
            cb_r       <= '0;
            y0_r       <= '0;
            cr_r       <= '0;
        end else begin
            e_pix      <= 1'b0;
            frame_done <= 1'b0;
            if (VSYNC) begin
                // A line ending on the same edge as VSYNC rises is not counted.
                if (vs_rise && row != '0) begin
                    frame_done <= 1'b1;
                end
                col      <= '0;
                row      <= '0;
                x        <= '0;
                y        <= '0;
                overflow <= 1'b0;
                line_pix <= 1'b0;
            end else begin
                if (href_fall) begin
                    col      <= '0;
                    line_pix <= 1'b0;
                    if (line_pix) begin
                        row <= row + 9'd1;
                    end
                end
                if (accept) begin
                    case (cur_phase)
                        PH_CB:   cb_r <= D;
                        PH_Y0:   y0_r <= D;
                        PH_CR:   cr_r <= D;
                        default: ;
                    endcase
                end
                if (pix_done) begin
                    // Saturating column keeps a long line from wrapping back into range.
                    if (col < H_LIM) begin
                        col <= col + 10'd1;
                    end
                    if (in_range) begin
                        e_pix    <= 1'b1;
                        line_pix <= 1'b1;
                        x        <= col;
                        y        <= row;
                        Cb       <= cb_r;
                        Cr       <= (cur_phase == PH_CR) ? D : cr_r;
                        Y        <= (cur_phase == PH_CR) ? y0_r : D;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ycbcr_capture.sv
// Directed bench for ycbcr_capture with a byte-level pixel model and a per-cycle compare process.
module tb_ycbcr_capture;

    localparam int H = 4;
    localparam int V = 3;

    logic       PCLK;
    logic       reset;
    logic       VSYNC;
    logic       HREF;
    logic [7:0] D;
    logic       e_pix;
    logic [7:0] Y, Cb, Cr;
    logic [9:0] x;
    logic [8:0] y;
    logic       frame_done;
    logic       overflow;

    ycbcr_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .PCLK       (PCLK),
        .reset      (reset),
        .VSYNC      (VSYNC),
        .HREF       (HREF),
        .D          (D),
        .e_pix      (e_pix),
        .Y          (Y),
        .Cb         (Cb),
        .Cr         (Cr),
        .x          (x),
        .y          (y),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    // ---------------- clock ----------------
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int unsigned cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int unsigned cyc;
        logic [7:0]  y;
        logic [7:0]  cb;
        logic [7:0]  cr;
        logic [9:0]  x;
        logic [8:0]  row;
    } pix_t;

    pix_t        exp_q[$];
    int unsigned fd_q[$];
    logic [7:0]  lb[$];

    int checks = 0;
    int errors = 0;

    bit m_armed = 0;
    int m_row   = 0;

    logic [7:0] hy = 0, hcb = 0, hcr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge PCLK) begin
        if (reset) begin
            hy  <= 8'd0;
            hcb <= 8'd0;
            hcr <= 8'd0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("pix_missing", 0, 1);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("e_pix_strobe", int'(e_pix), 1);
                chk("pix_Y",  int'(Y),  int'(exp_q[0].y));
                chk("pix_Cb", int'(Cb), int'(exp_q[0].cb));
                chk("pix_Cr", int'(Cr), int'(exp_q[0].cr));
                chk("pix_x",  int'(x),  int'(exp_q[0].x));
                chk("pix_y",  int'(y),  int'(exp_q[0].row));
                hy  <= exp_q[0].y;
                hcb <= exp_q[0].cb;
                hcr <= exp_q[0].cr;
                void'(exp_q.pop_front());
            end else begin
                chk("e_pix_idle", int'(e_pix), 0);
                chk("hold_Y",  int'(Y),  int'(hy));
                chk("hold_Cb", int'(Cb), int'(hcb));
                chk("hold_Cr", int'(Cr), int'(hcr));
            end
            if (fd_q.size() > 0 && fd_q[0] == cyc) begin
                chk("frame_done_pulse", int'(frame_done), 1);
                void'(fd_q.pop_front());
            end else begin
                chk("frame_done_idle", int'(frame_done), 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic vs, input logic hr, input logic [7:0] d);
        VSYNC = vs;
        HREF  = hr;
        D     = d;
        @(posedge PCLK);
        #1;
    endtask

    // VSYNC high for three cycles, then low; a frame with rows pulses frame_done.
    task automatic vsync_pulse();
        if (m_armed && m_row > 0) fd_q.push_back(cyc + 1);
        m_row = 0;
        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        m_armed = 1;
        step(1'b0, 1'b0, 8'd0);
    endtask

    // end_mode: 0 = HREF falls normally, 1 = HREF falls together with VSYNC rising,
    // 2 = HREF left high (line continues later).
    task automatic send_line(input int end_mode);
        int px;
        bit got;
        px  = 0;
        got = 0;
        for (int i = 0; i < lb.size(); i++) begin
            if (m_armed && (i % 4 == 2 || i % 4 == 3)) begin
                if (px < H && m_row < V) begin
                    pix_t p;
                    p.cyc = cyc + 1;
                    if (i % 4 == 2) begin
                        p.y = lb[i-1]; p.cb = lb[i-2]; p.cr = lb[i];
                    end else begin
                        p.y = lb[i];   p.cb = lb[i-3]; p.cr = lb[i-1];
                    end
                    p.x   = 10'(px);
                    p.row = 9'(m_row);
                    exp_q.push_back(p);
                    got = 1;
                end
                px++;
            end
            step(1'b0, 1'b1, lb[i]);
        end
        if (end_mode == 0) begin
            step(1'b0, 1'b0, 8'd0);
            if (got) m_row++;
            step(1'b0, 1'b0, 8'd0);
        end else if (end_mode == 1) begin
            vsync_pulse();
        end
    endtask

    task automatic seq_line(input int base, input int n);
        lb.delete();
        for (int i = 0; i < n; i++) lb.push_back(8'(base + i));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        VSYNC = 1'b0;
        HREF  = 1'b0;
        D     = 8'd0;
        @(posedge PCLK);
        #1;
        step(1'b0, 1'b0, 8'd0);
        chk("rst_e_pix", int'(e_pix), 0);
        chk("rst_Y", int'(Y), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        reset = 1'b0;
        step(1'b0, 1'b0, 8'd0);

        // Partial frame before any VSYNC: must be ignored.
        seq_line(50, 8);
        send_line(0);
        vsync_pulse();

        // Basic line.
        lb = {8'd80, 8'd10, 8'd90, 8'd20, 8'd81, 8'd11, 8'd91, 8'd21};
        send_line(0);
        chk("l1_Y", int'(Y), 21);
        chk("l1_Cb", int'(Cb), 81);
        chk("l1_Cr", int'(Cr), 91);
        chk("l1_x", int'(x), 3);
        chk("l1_y", int'(y), 0);

        // HREF drops after Cb,Y0 of the third group.
        seq_line(1, 10);
        send_line(0);
        chk("l2_Y", int'(Y), 8);
        chk("l2_x", int'(x), 3);
        chk("l2_y", int'(y), 1);
        chk("l2_overflow", int'(overflow), 0);

        // 12 bytes against H_ACTIVE=4: two pixels suppressed.
        seq_line(100, 12);
        send_line(0);
        chk("l3_Y", int'(Y), 107);
        chk("l3_Cb", int'(Cb), 104);
        chk("l3_x", int'(x), 3);
        chk("l3_y", int'(y), 2);
        chk("l3_overflow", int'(overflow), 1);

        // Fourth line beyond V_ACTIVE=3: suppressed entirely.
        seq_line(120, 4);
        send_line(0);
        chk("l4_Y_held", int'(Y), 107);
        chk("l4_overflow", int'(overflow), 1);

        vsync_pulse();
        chk("fr1_overflow_clr", int'(overflow), 0);
        chk("fr1_x_clr", int'(x), 0);
        chk("fr1_y_clr", int'(y), 0);

        // Empty frame: no frame_done.
        vsync_pulse();

        // Line ending together with VSYNC rising.
        seq_line(200, 4);
        send_line(0);
        seq_line(210, 4);
        send_line(1);
        seq_line(220, 4);
        send_line(0);
        chk("sim_Y", int'(Y), 223);
        chk("sim_y", int'(y), 0);

        // Vertical-only overflow.
        seq_line(230, 4);
        send_line(0);
        seq_line(240, 4);
        send_line(0);
        chk("v_y", int'(y), 2);
        chk("v_overflow_pre", int'(overflow), 0);
        seq_line(250, 4);
        send_line(0);
        chk("v_Y_held", int'(Y), 243);
        chk("v_overflow_post", int'(overflow), 1);
        vsync_pulse();

        // Reset after 5 bytes of a line.
        seq_line(20, 4);
        send_line(0);
        seq_line(30, 5);
        send_line(2);
        chk("pre_rst_Y", int'(Y), 33);
        chk("pre_rst_y", int'(y), 1);
        reset = 1'b1;
        #1;
        chk("arst_e_pix", int'(e_pix), 0);
        chk("arst_Y", int'(Y), 0);
        chk("arst_Cb", int'(Cb), 0);
        chk("arst_Cr", int'(Cr), 0);
        chk("arst_x", int'(x), 0);
        chk("arst_y", int'(y), 0);
        chk("arst_overflow", int'(overflow), 0);
        chk("arst_frame_done", int'(frame_done), 0);
        m_armed = 0;
        m_row   = 0;
        @(posedge PCLK);
        @(posedge PCLK);
        #1;
        reset = 1'b0;
        seq_line(35, 3);
        send_line(0);
        seq_line(60, 8);
        send_line(0);
        vsync_pulse();
        lb = {8'd70, 8'd71, 8'd72, 8'd73};
        send_line(0);
        chk("resume_Y", int'(Y), 73);
        chk("resume_Cr", int'(Cr), 72);
        chk("resume_y", int'(y), 0);

        repeat (4) step(1'b0, 1'b0, 8'd0);
        chk("pix_queue_drained", exp_q.size(), 0);
        chk("fd_queue_drained", fd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
